// File: rtl/ethernet_receive_slot_arbiter.sv
// Ethernet receive slot arbiter.
// Picks one buffered receive slot at a time in round-robin order and streams
// its head packet to the packet pusher through a 1-deep output register.
// Bad-FCS packets are drained without being forwarded.
// Optional watchdog: define ETHERNET_RECEIVE_SLOT_ARBITER_WATCHDOG_EN to
// abort a transfer whose slot stops presenting data for WATCHDOG_CYCLES cycles.
module ethernet_receive_slot_arbiter #(
  parameter int RECEIVE_QUE_SLOTS = 4,
  parameter int WATCHDOG_CYCLES   = 1024
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [RECEIVE_QUE_SLOTS-1:0]         slot_request,
  input  logic [RECEIVE_QUE_SLOTS-1:0]         slot_request_bad,
  input  logic [RECEIVE_QUE_SLOTS*8-1:0]       slot_packet_data,
  input  logic [RECEIVE_QUE_SLOTS-1:0]         slot_packet_data_valid,
  input  logic [RECEIVE_QUE_SLOTS-1:0]         slot_packet_last,
  output logic [RECEIVE_QUE_SLOTS-1:0]         slot_read_enable,
  output logic [8:0]                           pushed_data,
  output logic                                 pushed_data_valid,
  input  logic                                 pushed_data_ready,
  output logic [$clog2(RECEIVE_QUE_SLOTS)-1:0] grant_index,
  output logic                                 busy,
  output logic [15:0]                          packets_forwarded,
  output logic [15:0]                          packets_dropped,
  output logic                                 watchdog_abort
);

  localparam int GW = $clog2(RECEIVE_QUE_SLOTS);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] TRANSFER = 3'd1;
  localparam logic [2:0] DRAIN    = 3'd2;
  localparam logic [2:0] ABORT    = 3'd3;
  localparam logic [2:0] GAP      = 3'd4;

  if (RECEIVE_QUE_SLOTS < 2 || RECEIVE_QUE_SLOTS > 16 || WATCHDOG_CYCLES < 1) begin : g_param_check
    $error("ethernet_receive_slot_arbiter: parameter out of range");
  end

  logic [2:0]    state;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] rr_winner;
  logic          rr_found;
  logic [7:0]    sel_byte;
  logic          sel_valid;
  logic          sel_last;
  logic          sel_read;
  logic          accept;
  logic          stall;
  logic          wd_fire;
  logic          from_transfer;
  logic          abort_sent;

  // Round-robin search starting one past the last granted slot
  always_comb begin
    int unsigned idx;
    idx       = 0;
    rr_found  = 1'b0;
    rr_winner = '0;
    for (int unsigned off = 1; off <= RECEIVE_QUE_SLOTS; off++) begin
      idx = (int'(last_grant) + off) % RECEIVE_QUE_SLOTS;
      if (!rr_found && slot_request[idx]) begin
        rr_found  = 1'b1;
        rr_winner = GW'(idx);
      end
    end
  end

  // Head-of-slot mux for the granted slot
  always_comb begin
    sel_byte  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned i = 0; i < RECEIVE_QUE_SLOTS; i++) begin
      if (grant_index == GW'(i)) begin
        sel_byte  = slot_packet_data[i*8 +: 8];
        sel_valid = slot_packet_data_valid[i];
        sel_last  = slot_packet_last[i];
      end
    end
  end

  // Read strobe for the granted slot; reset blocks consumption immediately
  always_comb begin
    sel_read = 1'b0;
    if (!reset) begin
      if (state == TRANSFER) sel_read = !pushed_data_valid || pushed_data_ready;
      else if (state == DRAIN) sel_read = 1'b1;
    end
    slot_read_enable = '0;
    for (int unsigned i = 0; i < RECEIVE_QUE_SLOTS; i++) begin
      if (grant_index == GW'(i)) slot_read_enable[i] = sel_read;
    end
  end

  assign accept = sel_read && sel_valid;
  assign stall  = sel_read && !sel_valid;
  assign busy   = (state != IDLE);

`ifdef ETHERNET_RECEIVE_SLOT_ARBITER_WATCHDOG_EN
  localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
  logic [WW-1:0] wd_count;

  assign wd_fire = stall && (wd_count == WW'(WATCHDOG_CYCLES - 1));

  // Count consecutive starved read cycles while owning a slot
  always_ff @(posedge clock) begin
    if (reset || !stall || (state != TRANSFER && state != DRAIN)) wd_count <= '0;
    else wd_count <= wd_count + 1'b1;
  end

  // One-cycle abort pulse
  always_ff @(posedge clock) begin
    if (reset) watchdog_abort <= 1'b0;
    else watchdog_abort <= wd_fire;
  end
`else
  assign wd_fire        = 1'b0;
  assign watchdog_abort = 1'b0;
`endif

  // Arbitration FSM, output register and event counters
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      grant_index       <= '0;
      last_grant        <= GW'(RECEIVE_QUE_SLOTS - 1);
      pushed_data       <= 9'h000;
      pushed_data_valid <= 1'b0;
      packets_forwarded <= '0;
      packets_dropped   <= '0;
      from_transfer     <= 1'b0;
      abort_sent        <= 1'b0;
    end else begin
      if (pushed_data_valid && pushed_data_ready) pushed_data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rr_found) begin
            grant_index <= rr_winner;
            state       <= slot_request_bad[rr_winner] ? DRAIN : TRANSFER;
          end
        end
        TRANSFER: begin
          if (accept) begin
            pushed_data       <= {sel_last, sel_byte};
            pushed_data_valid <= 1'b1;
            if (sel_last) begin
              state <= GAP;
              if (packets_forwarded != '1) packets_forwarded <= packets_forwarded + 16'd1;
            end
          end else if (wd_fire) begin
            state         <= ABORT;
            from_transfer <= 1'b1;
            abort_sent    <= 1'b0;
            if (packets_dropped != '1) packets_dropped <= packets_dropped + 16'd1;
          end
        end
        DRAIN: begin
          if (accept && sel_last) begin
            state <= GAP;
            if (packets_dropped != '1) packets_dropped <= packets_dropped + 16'd1;
          end else if (wd_fire) begin
            state         <= ABORT;
            from_transfer <= 1'b0;
            abort_sent    <= 1'b0;
            if (packets_dropped != '1) packets_dropped <= packets_dropped + 16'd1;
          end
        end
        ABORT: begin
          // The abort marker waits until any byte still in the output
          // register has been taken, then holds until it is taken itself.
          if (!from_transfer) begin
            state <= GAP;
          end else if (!abort_sent) begin
            if (!pushed_data_valid || pushed_data_ready) begin
              pushed_data       <= 9'h100;
              pushed_data_valid <= 1'b1;
              abort_sent        <= 1'b1;
            end
          end else if (pushed_data_ready) begin
            state <= GAP;
          end
        end
        GAP: begin
          last_grant <= grant_index;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ethernet_receive_slot_arbiter.md
ETHERNET_RECEIVE_SLOT_ARBITER -- requirements
Module: ethernet_receive_slot_arbiter

Interface
REQ-001 SHALL have parameter RECEIVE_QUE_SLOTS, default 4, number of receive queue slots arbitrated (2..16).
REQ-002 SHALL have parameter WATCHDOG_CYCLES, default 1024, stall limit used only when the watchdog is compiled in.
REQ-003 clock  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 slot_request  input  [N]  slot holds at least one complete buffered packet.
REQ-006 slot_request_bad  input  [N]  head packet of slot failed FCS; qualified by slot_request.
REQ-007 slot_packet_data  input  [N][7:0]  head byte of each slot.
REQ-008 slot_packet_data_valid  input  [N]  head byte valid.
REQ-009 slot_packet_last  input  [N]  head byte is last byte of packet.
REQ-010 slot_read_enable  output  [N]  one-hot read strobe; slot advances when read_enable && data_valid.
REQ-011 pushed_data  output  9  {last, byte} to packet pusher.
REQ-012 pushed_data_valid  output  1  pushed_data valid.
REQ-013 pushed_data_ready  input  1  downstream accepts pushed_data this cycle.
REQ-014 grant_index  output  $clog2(N)  slot currently owned; busy  output  1  FSM not in IDLE.
REQ-015 packets_forwarded, packets_dropped  output  16 each  saturating event counters.
REQ-016 watchdog_abort  output  1  one-cycle pulse on watchdog abort; constant 0 when watchdog compiled out.

Function
REQ-017 FSM states SHALL be IDLE, TRANSFER, DRAIN, ABORT, GAP.
REQ-018 IDLE: if any slot_request, latch round-robin winner into grant_index; go TRANSFER if its slot_request_bad=0, else DRAIN; no requests -> stay IDLE.
REQ-019 Round-robin: search starts at slot after last granted, wraps N-1 -> 0; after reset slot 0 has top priority.
REQ-020 TRANSFER: slot_read_enable[grant_index] = !pushed_data_valid || pushed_data_ready (combinational); all other bits 0.
REQ-021 Accepted byte (read_enable && data_valid) SHALL appear on pushed_data with pushed_data_valid exactly 1 cycle later; bit 8 = slot_packet_last.
REQ-022 pushed_data/pushed_data_valid SHALL hold stable while pushed_data_valid && !pushed_data_ready; no byte lost or duplicated under backpressure.
REQ-023 DRAIN: slot_read_enable[grant_index]=1 every cycle; bytes discarded, pushed_data_valid not asserted by drained bytes.
REQ-024 Accepted last byte in TRANSFER -> GAP, packets_forwarded +1; in DRAIN -> GAP, packets_dropped +1.
REQ-025 GAP: exactly one cycle, no read_enable, lets slot update slot_request; then IDLE; last-granted pointer updated to grant_index.
REQ-026 Single requester SHALL be granted back-to-back packets (IDLE-TRANSFER-GAP-IDLE) with no starvation of others: with all N requesting, each slot granted once per N packets.
REQ-027 Counters SHALL saturate at 16'hFFFF, never wrap.
REQ-028 slot_request deasserting mid-packet SHALL be ignored; grant held until last byte or abort.

Reset
REQ-029 On reset: FSM IDLE, grant_index 0, last-granted pointer N-1, pushed_data 9'h000, pushed_data_valid 0, slot_read_enable 0, counters 0, watchdog_abort 0, watchdog counter 0.
REQ-030 Reset mid-packet SHALL abandon the packet immediately, no further bytes emitted; takes priority over all other events.

Configuration
REQ-031 Macro ETHERNET_RECEIVE_SLOT_ARBITER_WATCHDOG_EN compiles the watchdog in.
REQ-032 With macro: in TRANSFER/DRAIN a counter counts consecutive cycles read_enable=1 and data_valid=0; reaching WATCHDOG_CYCLES -> ABORT, watchdog_abort pulse, packets_dropped +1.
REQ-033 ABORT: present pushed_data=9'h100 valid (only if packet came from TRANSFER), hold until accepted, then GAP; from DRAIN go GAP directly.
REQ-034 Without macro: no watchdog counter, ABORT unreachable, watchdog_abort tied 0; a stalled slot holds the grant indefinitely.

Verification
REQ-035 Slot 2 requests, 3-byte good packet AA,BB,CC, ready=1 -> pushed 0AA,0BB,1CC on consecutive cycles, packets_forwarded=1.
REQ-036 Slots 0,1,3 request continuously -> grant order 0,1,3,0,1,3.
REQ-037 Slot 1 request with slot_request_bad=1, 64 bytes -> zero pushed_data_valid, packets_dropped=1, slot drained.
REQ-038 Ready toggles 1,0,0,1 during 4-byte packet -> all 4 bytes delivered once, in order, data stable while stalled.
REQ-039 Watchdog built, WATCHDOG_CYCLES=16, slot stalls after byte 2 -> watchdog_abort at cycle 16 of stall, pushed 9'h100, FSM GAP then IDLE.
REQ-040 Reset asserted mid-transfer -> next cycle all outputs at reset values, slot 0 highest priority afterwards.
